// File: rtl/radix4_booth_result_buffer_if.sv
// Bundles the multiplier-result capture inputs and the consumer valid/ready side of the result buffer.
// With RADIX4_BOOTH_RESULT_DROP_CNT_EN defined the interface also carries the 16-bit drop counter.
interface radix4_booth_result_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 mult_done;
    logic [2*WIDTH-1:0]   mult_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_data;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
`ifdef RADIX4_BOOTH_RESULT_DROP_CNT_EN
    logic [15:0]          drop_cnt;

    modport master (
        output mult_done, mult_result, out_ready,
        input  out_valid, out_data, count, full, empty, overflow, drop_cnt
    );
    modport slave (
        input  mult_done, mult_result, out_ready,
        output out_valid, out_data, count, full, empty, overflow, drop_cnt
    );
`else
    modport master (
        output mult_done, mult_result, out_ready,
        input  out_valid, out_data, count, full, empty, overflow
    );
    modport slave (
        input  mult_done, mult_result, out_ready,
        output out_valid, out_data, count, full, empty, overflow
    );
`endif
endinterface

// File: rtl/radix4_booth_result_buffer.sv
// Captures one product per Booth multiplication (rising edge of done) into a DEPTH-entry FIFO drained by valid/ready.
// Optional macro RADIX4_BOOTH_RESULT_DROP_CNT_EN adds a saturating 16-bit drop counter that backs the overflow flag.
module radix4_booth_result_buffer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit CHECK_PARAM = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    radix4_booth_result_buffer_if.slave bus
);
    localparam int PW = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    generate
        if (CHECK_PARAM) begin : g_check
            if (WIDTH == 0 || DEPTH < 2) begin : g_bad
                $fatal(1, "radix4_booth_result_buffer: WIDTH must be > 0 and DEPTH >= 2");
            end
        end
    endgenerate

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_q;
    logic               done_q;
    logic               capture_pending;
    logic               done_rise;
    logic               is_empty;
    logic               is_full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign done_rise = bus.mult_done & ~done_q;
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == FULL_CNT);
    assign pop       = ~is_empty & bus.out_ready;
    // A full FIFO still accepts the product when the head is leaving in the same cycle.
    assign push_ok   = capture_pending & (~is_full | pop);
    assign drop      = capture_pending & is_full & ~pop;

    assign bus.out_valid = ~is_empty;
    assign bus.out_data  = is_empty ? '0 : mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= bus.mult_result;
        end
    end

`ifdef RADIX4_BOOTH_RESULT_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    assign bus.drop_cnt = drop_cnt_q;
    assign bus.overflow = (drop_cnt_q != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (flush) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    logic overflow_q;

    assign bus.overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end
`endif

    // mult_result becomes valid one cycle after the done edge, hence the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            done_q          <= 1'b0;
            capture_pending <= 1'b0;
        end else if (flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            done_q          <= 1'b0;
            capture_pending <= 1'b0;
        end else begin
            done_q          <= bus.mult_done;
            capture_pending <= done_rise;
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: doc/radix4_booth_result_buffer.md
Name: radix4_booth_result_buffer

Overview:
Downstream stage of the radix-4 Booth multiplier data path. It detects each completed multiplication from the data path's done/result outputs and captures exactly one product per operation into a DEPTH-entry FIFO. It presents the stored products to the consumer over a valid/ready handshake, so the multiplier can keep running while the consumer stalls.

Parameters:
WIDTH, 8, multiplier operand width; stored product width is 2*WIDTH
DEPTH, 4, number of FIFO entries; must be >= 2, need not be a power of two
CHECK_PARAM, 1, when 1: $fatal at elaboration if WIDTH==0 or DEPTH<2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stored and pending products
mult_done  input  1  data path done (level, may stay high several cycles)
mult_result  input  2*WIDTH  data path result register
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  2*WIDTH  head entry product, raw two's-complement bits
count  output  $clog2(DEPTH+1)  entries stored
full  output  1  count==DEPTH
empty  output  1  count==0
overflow  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n low): pointers=0, count=0, out_valid=0, out_data=0, full=0, empty=1, overflow=0, done_q=0, capture_pending=0. Stored entries need not be cleared.
- Edge detect: done_q <= mult_done each cycle. done_rise = mult_done & ~done_q. A done level held for N cycles yields one capture.
- Capture timing: the data path updates mult_result on the edge that ends the done_rise cycle T. capture_pending is set at that same edge. In cycle T+1, mult_result is written (push) and capture_pending clears. The product is visible on out_data/out_valid in cycle T+2 if the FIFO was empty.
- Pop: occurs when out_valid & out_ready. The read pointer advances at the clock edge. out_data is combinational from the head entry, and it is held stable while out_valid & ~out_ready.
- Push when full with no pop in the same cycle: the product is dropped, overflow is set (sticky until reset or flush), and contents are unchanged.
- Push and pop in the same cycle when full: both take effect; count stays DEPTH and nothing is dropped.
- Push and pop in the same cycle when empty: out_valid is low, so there is no pop. The push takes effect; no bypass.
- Pointers wrap from DEPTH-1 to 0. count increments on push-only, decrements on pop-only, and is unchanged on both or neither.
- flush (highest priority after reset): at the clock edge, pointers, count and overflow go to 0, and capture_pending and done_q clear. A push or pop in the flush cycle is discarded and is not counted as overflow. A done_rise in the flush cycle is ignored.
- Reset asserted mid-capture (capture_pending=1) discards the pending product.
- full/empty/count are registered-consistent: derived from count, with no combinational dependence on out_ready.

Optional Feature:
Macro RADIX4_BOOTH_RESULT_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0]. It increments on each dropped capture and saturates at 16'hFFFF. It is cleared by reset and by flush. overflow equals (drop_cnt != 0).
- Undefined: no drop_cnt port; overflow is a single sticky flop as described above.

Test Plan:
Each scenario uses WIDTH=8, DEPTH=4.
- Single op: mult_done high in cycle 10 only, mult_result=16'hFFF4 from cycle 11 (-3*4), out_ready=1 -> push in cycle 11; out_valid=1 with out_data=16'hFFF4 in cycle 12 only; count returns to 0.
- Held done: mult_done high in cycles 10-13, mult_result=16'h0051 -> exactly one entry captured; count=1 until popped.
- Fill/overflow: 5 ops with results 1,2,3,4,5 and out_ready=0 -> full=1, count=4, overflow=1. Then out_ready=1 -> out_data sequence 1,2,3,4, then empty=1.
- Full with simultaneous pop: FIFO holds 1-4, out_ready=1 in the push cycle of result 9 -> no drop, overflow=0, drain order 2,3,4,9.
- Flush: 3 entries stored and capture_pending=1, flush pulsed -> count=0, empty=1, overflow=0; the pending product never appears.
- Async reset mid-stream: rst_n low for 1 ns between edges with 2 entries -> immediately out_valid=0, count=0. After release, a new op is captured normally. With RADIX4_BOOTH_RESULT_DROP_CNT_EN defined, 6 drops give drop_cnt=6.
